pllcfg_seq: RTL

PLLCFG_SEQ -- requirements
Module: pllcfg_seq

---
 rtl/pllcfg_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pllcfg_seq.sv
// PLL configuration sequencer: per-channel reset pulse, lock wait and
// reconfig handshake with sticky status and timeout reporting.
module pllcfg_seq #(
  parameter int N_PLL   = 6,
  parameter int SEL_W   = 3,
  parameter int RST_CYC = 16,
  parameter int TO_CYC  = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [N_PLL-1:0] pll_locked,
  output logic [N_PLL-1:0] pll_rst,
  output logic [N_PLL-1:0] recfg_start,
  input  logic [N_PLL-1:0] recfg_done,
  output logic             stat_busy,
  output logic             stat_done,
  output logic             stat_err,
  output logic [1:0]       stat_code,
  output logic [SEL_W-1:0] stat_sel
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_LOCKW = 3'd2;
  localparam logic [2:0] S_RCFG  = 3'd3;
  localparam logic [2:0] S_RCFGW = 3'd4;

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
  localparam logic [N_PLL-1:0] ONE = N_PLL'(1);

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic             rcfg_q;
  logic [RW-1:0]    rst_cnt;
  logic [15:0]      to_cnt;
  logic [SEL_W-1:0] sel_q;
  logic [N_PLL-1:0] sel_oh;
  logic             hit_lock;
  logic             hit_done;
  logic             to_hit;
  logic             bad_sel;

  // Outputs decode from state so an async reset drops them at once.
  assign sel_oh      = ONE << sel_q;
  assign hit_lock    = |(pll_locked & sel_oh);
  assign hit_done    = |(recfg_done & sel_oh);
  assign to_hit      = (to_cnt == TO_LAST);
  assign bad_sel     = 32'(cmd_sel) >= 32'(N_PLL);
  assign cmd_ready   = reset_n && (state == S_IDLE);
  assign stat_busy   = (state != S_IDLE);
  assign pll_rst     = (state == S_RST) ? sel_oh : '0;
  assign recfg_start = (state == S_RCFG) ? sel_oh : '0;
  assign stat_sel    = sel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      rcfg_q    <= 1'b0;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      sel_q     <= '0;
      stat_done <= 1'b0;
      stat_err  <= 1'b0;
      stat_code <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sel_q     <= cmd_sel;
            op_q      <= cmd_op;
            rcfg_q    <= 1'b0;
            rst_cnt   <= '0;
            stat_done <= 1'b0;
            stat_err  <= 1'b0;
            stat_code <= 2'd0;
            if (cmd_op == 2'b11) begin
              state <= S_IDLE;
            end else if (bad_sel) begin
              stat_err  <= 1'b1;
              stat_code <= 2'd3;
            end else if (cmd_op == 2'b01) begin
              state <= S_RCFG;
            end else begin
              state <= S_RST;
            end
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state  <= S_LOCKW;
            to_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_LOCKW: begin
          if (hit_lock) begin
            if (op_q == 2'b10 && !rcfg_q) begin
              state <= S_RCFG;
            end else begin
              stat_done <= 1'b1;
              state     <= S_IDLE;
            end
          end else if (to_hit) begin
            stat_err  <= 1'b1;
            stat_code <= 2'd1;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RCFG: begin
          rcfg_q <= 1'b1;
          to_cnt <= '0;
          state  <= S_RCFGW;
        end
        S_RCFGW: begin
          if (hit_done) begin
            to_cnt <= '0;
            state  <= S_LOCKW;
          end else if (to_hit) begin
            stat_err  <= 1'b1;
            stat_code <= 2'd2;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
